// File: rtl/ns_rr_arb.sv
// ns_rr_arb -- round-robin arbiter with registered one-hot and binary grant.
//
// A request vector is arbitrated from a rotating priority pointer. The grant is
// held until gnt_rdy accepts it. On an accept, the pointer moves past the
// accepted index. The remaining requesters (excluding the one just served) are
// then re-arbitrated in the same cycle, so grants can issue back-to-back.
//
// Optional feature: define NS_RR_ARB_LOCK_EN to honour 'lock'. An accept with
// lock=1 then keeps the current grant and pointer. When the macro is not
// defined, the lock port is present but ignored.
//
// Parameters
//   SEL_WIDTH  number of requesters (2..32)
//   IDX_WIDTH  $clog2(SEL_WIDTH), width of gnt_idx
// Ports
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   req      per-requester level request
//   lock     keep current grant across an accept (see macro above)
//   gnt_rdy  downstream accepts the presented grant
//   gnt_vld  grant presented (registered)
//   gnt_oh   one-hot grant (registered), all-zero when idle
//   gnt_idx  binary index of gnt_oh (registered)
module ns_rr_arb #(
  parameter  int SEL_WIDTH = 8,
  localparam int IDX_WIDTH = $clog2(SEL_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_WIDTH-1:0] req,
  input  logic                 lock,
  input  logic                 gnt_rdy,
  output logic                 gnt_vld,
  output logic [SEL_WIDTH-1:0] gnt_oh,
  output logic [IDX_WIDTH-1:0] gnt_idx
);

`ifdef NS_RR_ARB_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   ptr_q, ptr_d, ptr_inc;
  logic [SEL_WIDTH-1:0]   oh_d;
  logic [IDX_WIDTH-1:0]   idx_d;
  logic                   accept, hold_lock;

  logic [SEL_WIDTH-1:0]   arb_req, arb_mask, arb_hi, arb_src, arb_pick;
  logic [IDX_WIDTH-1:0]   arb_ptr, pick_idx;

  assign accept    = (state_q == GRANT) && gnt_rdy;
  assign hold_lock = accept && LOCK_EN && lock;
  // Pointer after serving gnt_idx; explicit wrap for non-power-of-2 widths.
  assign ptr_inc   = (gnt_idx == IDX_WIDTH'(SEL_WIDTH-1)) ? '0
                                                          : gnt_idx + IDX_WIDTH'(1);

  // Round-robin pick: search requests at or above the pointer first; if none,
  // fall back to the whole vector, which then wraps to the lowest set bit.
  always_comb begin
    arb_ptr = accept ? ptr_inc : ptr_q;
    // Current holder is excluded on accept; gnt_oh is zero in IDLE anyway.
    arb_req = (state_q == GRANT) ? (req & ~gnt_oh) : req;
    for (int i = 0; i < SEL_WIDTH; i++)
      arb_mask[i] = (IDX_WIDTH'(i) >= arb_ptr);
    arb_hi   = arb_req & arb_mask;
    arb_src  = (|arb_hi) ? arb_hi : arb_req;
    arb_pick = arb_src & (~arb_src + SEL_WIDTH'(1));  // isolate lowest set bit
    pick_idx = '0;
    for (int i = 0; i < SEL_WIDTH; i++)
      if (arb_pick[i]) pick_idx = pick_idx | IDX_WIDTH'(i);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (|req) state_d = GRANT;
      GRANT: if (accept && !hold_lock) state_d = (|arb_pick) ? GRANT : IDLE;
    endcase
  end

  // Next output/pointer values
  always_comb begin
    oh_d  = gnt_oh;
    idx_d = gnt_idx;
    ptr_d = ptr_q;
    case (state_q)
      IDLE: begin
        oh_d  = arb_pick;       // zero when req == 0
        idx_d = pick_idx;
      end
      GRANT: begin
        if (accept && !hold_lock) begin
          ptr_d = ptr_inc;
          oh_d  = arb_pick;
          idx_d = pick_idx;
        end
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_vld <= 1'b0;
      gnt_oh  <= '0;
      gnt_idx <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_vld <= (state_d == GRANT);
      gnt_oh  <= oh_d;
      gnt_idx <= idx_d;
    end
  end

endmodule

// File: tb/tb_ns_rr_arb.sv
// Testbench for ns_rr_arb (SEL_WIDTH=4): directed scenarios with constant
// expectations, then a randomized phase checked against a behavioural model.
// Expected outputs are queued when inputs are driven (at negedge) and popped
// and compared 1 time unit after the following rising edge.
module tb_ns_rr_arb;
  localparam int W  = 4;
  localparam int IW = 2;

`ifdef NS_RR_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  req = '0;
  logic          lock = 1'b0;
  logic          gnt_rdy = 1'b0;
  logic          gnt_vld;
  logic [W-1:0]  gnt_oh;
  logic [IW-1:0] gnt_idx;

  ns_rr_arb #(.SEL_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .gnt_rdy(gnt_rdy),
    .gnt_vld(gnt_vld), .gnt_oh(gnt_oh), .gnt_idx(gnt_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic          vld;
    logic [W-1:0]  oh;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: compare the oldest expectation just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".vld"}, 32'(gnt_vld), 32'(e.vld));
      chk({e.tag, ".oh"},  32'(gnt_oh),  32'(e.oh));
      chk({e.tag, ".idx"}, 32'(gnt_idx), 32'(e.idx));
    end
  end

  task automatic step(input string tag, input logic r, input logic [W-1:0] rq,
                      input logic lk, input logic rdy,
                      input logic ev, input logic [W-1:0] eoh, input logic [IW-1:0] eidx);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; lock = lk; gnt_rdy = rdy;
    e.tag = tag; e.vld = ev; e.oh = eoh; e.idx = eidx;
    q.push_back(e);
  endtask

  // Behavioural reference for the random phase
  logic          m_vld;
  logic [W-1:0]  m_oh;
  logic [IW-1:0] m_idx;
  int            m_ptr;

  task automatic m_search(input logic [W-1:0] r, input int from);
    m_vld = 1'b0; m_oh = '0; m_idx = '0;
    for (int k = 0; k < W; k++) begin
      int n;
      n = (from + k) % W;
      if (r[n]) begin
        m_vld = 1'b1; m_oh = '0; m_oh[n] = 1'b1; m_idx = IW'(n);
        break;
      end
    end
  endtask

  task automatic m_step(input logic r, input logic [W-1:0] rq,
                        input logic lk, input logic rdy);
    if (r) begin
      m_vld = 1'b0; m_oh = '0; m_idx = '0; m_ptr = 0;
    end else if (!m_vld) begin
      m_search(rq, m_ptr);
    end else if (rdy && !(LOCK_EN && lk)) begin
      logic [W-1:0] rem;
      rem   = rq & ~m_oh;
      m_ptr = (int'(m_idx) + 1) % W;
      m_search(rem, m_ptr);
    end
  endtask

  initial begin
    // Reset, first grant from ptr=0
    step("rst0",  1, 4'b0000, 0, 0, 0, 4'b0000, 0);
    step("g1010", 0, 4'b1010, 0, 0, 1, 4'b0010, 1);
    // Stall: grant holds while req changes, incl. withdrawal
    for (int i = 0; i < 3; i++)
      step("stall", 0, 4'b0001, 0, 0, 1, 4'b0010, 1);
    step("post_stall", 0, 4'b0001, 0, 1, 1, 4'b0001, 0);
    step("to_idle",    0, 4'b0000, 0, 1, 0, 4'b0000, 0);
    step("idle_hold",  0, 4'b0000, 0, 0, 0, 4'b0000, 0);

    // Full rotation with back-to-back grants
    step("rst1",  1, 4'b0000, 0, 0, 0, 4'b0000, 0);
    step("rot0",  0, 4'b1111, 0, 1, 1, 4'b0001, 0);
    step("rot1",  0, 4'b1111, 0, 1, 1, 4'b0010, 1);
    step("rot2",  0, 4'b1111, 0, 1, 1, 4'b0100, 2);
    step("rot3",  0, 4'b1111, 0, 1, 1, 4'b1000, 3);
    step("rot4",  0, 4'b1111, 0, 1, 1, 4'b0001, 0);

    // Sole continuous requester alternates
    step("rst2",  1, 4'b0000, 0, 0, 0, 4'b0000, 0);
    step("sole1", 0, 4'b0100, 0, 1, 1, 4'b0100, 2);
    step("sole2", 0, 4'b0100, 0, 1, 0, 4'b0000, 0);
    step("sole3", 0, 4'b0100, 0, 1, 1, 4'b0100, 2);
    step("sole4", 0, 4'b0100, 0, 1, 0, 4'b0000, 0);

    // Lock
    step("rst3",  1, 4'b0000, 0, 0, 0, 4'b0000, 0);
    step("lk_a",  0, 4'b1111, 0, 0, 1, 4'b0001, 0);
    step("lk_b",  0, 4'b1111, 0, 1, 1, 4'b0010, 1);
    if (LOCK_EN) begin
      step("lk_h1", 0, 4'b1111, 1, 1, 1, 4'b0010, 1);
      step("lk_h2", 0, 4'b1111, 1, 1, 1, 4'b0010, 1);
      step("lk_rl", 0, 4'b1111, 0, 1, 1, 4'b0100, 2);
    end else begin
      step("nlk1",  0, 4'b1111, 1, 1, 1, 4'b0100, 2);
      step("nlk2",  0, 4'b1111, 1, 1, 1, 4'b1000, 3);
      step("nlk3",  0, 4'b1111, 0, 1, 1, 4'b0001, 0);
    end

    // Reset mid-grant with ptr=2 takes priority and clears the pointer
    step("rst4",  1, 4'b0000, 0, 0, 0, 4'b0000, 0);
    step("p0",    0, 4'b1111, 0, 0, 1, 4'b0001, 0);
    step("p1",    0, 4'b1111, 0, 1, 1, 4'b0010, 1);
    step("p2",    0, 4'b1111, 0, 1, 1, 4'b0100, 2);
    step("rst_pri", 1, 4'b1111, 1, 1, 0, 4'b0000, 0);
    step("post_rst", 0, 4'b1111, 0, 0, 1, 4'b0001, 0);

    // Random phase against the model
    m_step(1, '0, 0, 0);
    step("rnd_rst", 1, 4'b0000, 0, 0, m_vld, m_oh, m_idx);
    for (int i = 0; i < 400; i++) begin
      logic         r, lk, rdy;
      logic [W-1:0] rq;
      r   = ($urandom_range(0, 49) == 0);
      rq  = W'($urandom_range(0, 15));
      lk  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      m_step(r, rq, lk, rdy);
      step("rnd", r, rq, lk, rdy, m_vld, m_oh, m_idx);
    end

    @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
